// File: rtl/ram_access_ctrl_pkg.sv
// Shared constants for the data-RAM load/store front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the access-size encodings, FSM state encodings, the legacy
// RstEnable/WriteEnable/ZeroWord constants and the alignment check shared
// by the controller and its lane-alignment datapath.
package ram_access_ctrl_pkg;

  // Legacy constants kept for code that already refers to them.
  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Access size as presented by the memory stage.
  typedef logic [1:0] size_t;
  localparam size_t SizeByte = 2'b00;
  localparam size_t SizeHalf = 2'b01;
  localparam size_t SizeWord = 2'b10;
  localparam size_t SizeRsvd = 2'b11;

  // Controller FSM encodings.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StMerge = 2'd1;
  localparam state_t StDone  = 2'd2;

  // A request is misaligned when its size does not divide its byte offset.
  // The reserved size encoding is always rejected.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = off[0];
      SizeWord: mis = (off != 2'b00);
      SizeRsvd: mis = 1'b1;
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Bundle of the core-side request port and the RAM-side port of the controller.
// Latency: n/a (wiring only).
// Backpressure: request is held by the core until ack_o; RAM never stalls.
//
// Core side : req_i, we_i, size_i, unsigned_i, addr_i, data_i -> ack_o, err_o, data_o
// RAM side  : ram_we_o, ram_addr_o, ram_data_o -> RAM, ram_data_i <- RAM (comb read)
// slave  modport : the controller.
// master modport : the core plus RAM (or a testbench standing in for both).
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import ram_access_ctrl_pkg::*;

  // core -> controller
  logic              req_i;
  logic              we_i;
  size_t             size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;

  // controller -> core
  logic              ack_o;
  logic              err_o;
  logic [DATA_W-1:0] data_o;

  // controller <-> RAM
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [DATA_W-1:0] ram_data_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, data_i, ram_data_i,
    output ack_o, err_o, data_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, data_i, ram_data_i,
    input  ack_o, err_o, data_o, ram_we_o, ram_addr_o, ram_data_o
  );

endinterface

// File: rtl/ram_access_ctrl_mem_lane_align.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   size_i      access size (byte/half/word)
//   off_i       byte offset within the word (addr[1:0]), little-endian lanes
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   rdata_i     word read from the RAM
//   wdata_i     right-justified store data
//   ld_data_o   aligned, extended load result
//   st_data_o   rdata_i with the addressed lane(s) replaced by wdata_i
module mem_lane_align
  import ram_access_ctrl_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic        sign8;
  logic        sign16;

  // Lane select: byte lane n sits at bits [8n+7:8n]; halfword lanes are
  // picked by off_i[1] only (off_i[0] set is a misaligned half, never merged).
  always_comb begin
    lane8  = rdata_i[{off_i, 3'b000} +: 8];
    lane16 = rdata_i[{off_i[1], 4'b0000} +: 16];
    sign8  = ~unsigned_i & lane8[7];
    sign16 = ~unsigned_i & lane16[15];
  end

  always_comb begin
    ld_data_o = ZeroWord;
    case (size_i)
      SizeByte: ld_data_o = {{24{sign8}}, lane8};
      SizeHalf: ld_data_o = {{16{sign16}}, lane16};
      SizeWord: ld_data_o = rdata_i;
      default:  ld_data_o = ZeroWord;
    endcase
  end

  always_comb begin
    st_data_o = rdata_i;
    case (size_i)
      SizeByte: st_data_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SizeHalf: st_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SizeWord: st_data_o = wdata_i;
      default:  st_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store front-end for a word-wide data RAM with no byte enables.
// Latency: ack 1 cycle after acceptance for loads/word stores/errors, 2 for sub-word stores.
// Backpressure: core holds req_i until ack_o; one request in flight, req_i ignored in DONE.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        ram_access_ctrl_if.slave: core request/response and RAM port
//
// Sub-word stores are read-modify-write: the RAM word is read combinationally
// in the accepting IDLE cycle, merged, and written back from the merge
// register in the following MERGE cycle.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  ram_access_ctrl_if.slave    bus
);

  // Registered state.
  state_t            state_q,  state_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [DATA_W-1:0] merge_q,  merge_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;

  // Request decode.
  logic              accept;
  logic              mis;
  logic              word_store_now;
  logic              wr_now;
  logic [ADDR_W-1:0] addr_aligned;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;

  assign addr_aligned   = {bus.addr_i[ADDR_W-1:2], 2'b00};
  assign mis            = is_misaligned(bus.size_i, bus.addr_i[1:0]);
  assign accept         = (state_q == StIdle) && bus.req_i;
  assign word_store_now = accept && bus.we_i && !mis && (bus.size_i == SizeWord);

  mem_lane_align u_lane (
    .size_i     (bus.size_i),
    .off_i      (bus.addr_i[1:0]),
    .unsigned_i (bus.unsigned_i),
    .rdata_i    (bus.ram_data_i),
    .wdata_i    (bus.data_i),
    .ld_data_o  (ld_data),
    .st_data_o  (st_data)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    data_d  = data_q;
    merge_d = merge_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (mis) begin
            // Rejected before touching the RAM; load result is cleared.
            err_d  = 1'b1;
            data_d = ZeroWord;
          end else if (!bus.we_i) begin
            data_d = ld_data;
          end else if (bus.size_i != SizeWord) begin
            // Read half of the RMW happens now; the write goes out next cycle.
            merge_d = st_data;
            addr_d  = addr_aligned;
            state_d = StMerge;
          end
        end
      end
      StMerge: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      data_q  <= ZeroWord;
      merge_q <= ZeroWord;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      data_q  <= data_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

  // RAM port. The write enable is gated by rst directly so an in-flight
  // MERGE write is dropped the moment reset rises, not on the next edge.
  assign wr_now         = (rst != RstEnable) && (word_store_now || (state_q == StMerge));
  assign bus.ram_we_o   = wr_now ? WriteEnable : ~WriteEnable;
  assign bus.ram_addr_o = (state_q == StMerge) ? addr_q : addr_aligned;
  assign bus.ram_data_o = (state_q == StMerge) ? merge_q : bus.data_i;

  // Core response.
  assign bus.ack_o  = (state_q == StDone);
  assign bus.err_o  = (state_q == StDone) && err_q;
  assign bus.data_o = data_q;

endmodule
